// File: rtl/imem_port_arbiter_if.sv
// Fetcher, LSU and memory-port signals of the shared instruction/data port.
// slave: the arbiter; master: requesters plus the memory macro's read data.
interface imem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_stall;
    logic [63:0] if_rdata;
    logic        if_rvalid;

    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [63:0] ls_wdata;
    logic [7:0]  ls_wmask;
    logic        ls_stall;
    logic [63:0] ls_rdata;
    logic        ls_rvalid;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [63:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wmask, mem_rdata,
        output if_stall, if_rdata, if_rvalid, ls_stall, ls_rdata, ls_rvalid,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wmask, mem_rdata,
        input  if_stall, if_rdata, if_rvalid, ls_stall, ls_rdata, ls_rvalid,
               mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single 64-bit memory port between fetcher and LSU (LSU priority).
// Define IMEM_ARB_STARVE_GUARD_EN to force a fetch win after MAX_WAIT lost cycles.
module imem_port_arbiter #(
    parameter int unsigned MAX_WAIT = 4
) (
    input logic                  clk,
    input logic                  reset,
    imem_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LS_RD
    } owner_t;

    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF8;

    owner_t owner_q, owner_d;
    logic   grant_if, grant_ls;
    logic   force_if;

`ifdef IMEM_ARB_STARVE_GUARD_EN
    logic [3:0] wait_q;

    assign force_if = (wait_q == 4'(MAX_WAIT));

    // Counts consecutive cycles the fetcher lost to the LSU; saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset || grant_if || !bus.if_req) begin
            wait_q <= '0;
        end else if (grant_ls && wait_q != '1) begin
            wait_q <= wait_q + 4'd1;
        end
    end
`else
    assign force_if = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        owner_d  = OWN_NONE;
        if (!reset) begin
            if (bus.ls_req && !(bus.if_req && force_if)) begin
                grant_ls = 1'b1;
            end else if (bus.if_req) begin
                grant_if = 1'b1;
            end
        end
        if (grant_if) begin
            owner_d = OWN_IF;
        end else if (grant_ls && !bus.ls_we) begin
            owner_d = OWN_LS_RD;
        end
    end

    always_comb begin
        bus.mem_en    = grant_if | grant_ls;
        bus.mem_we    = grant_ls & bus.ls_we;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wmask = '0;
        if (grant_ls) begin
            bus.mem_addr = bus.ls_addr & LINE_MASK;
            if (bus.ls_we) begin
                bus.mem_wdata = bus.ls_wdata;
                bus.mem_wmask = bus.ls_wmask;
            end
        end else if (grant_if) begin
            bus.mem_addr = bus.if_addr & LINE_MASK;
        end

        // Stalls and responses are forced low during reset, including a pending read.
        bus.if_stall  = !reset && bus.if_req && !grant_if;
        bus.ls_stall  = !reset && bus.ls_req && !grant_ls;
        bus.if_rvalid = !reset && (owner_q == OWN_IF);
        bus.ls_rvalid = !reset && (owner_q == OWN_LS_RD);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
        bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : '0;
    end

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Shares the single 64-bit, one-cycle-latency instruction/data memory port between the instruction fetcher (fetch-line reads) and the load/store unit (reads and byte-masked writes). Each cycle it grants the port to at most one requester. It stalls the loser and routes the returning read data to the owner of the previous cycle's access. It sits between the fetch/LSU stages and the on-chip memory macro.

## Interface
- `MAX_WAIT`, default 4: consecutive lost cycles after which the fetcher is forced to win (starvation guard); legal range 1..15.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `if_req`  in  1  fetcher requests a read this cycle
- `if_addr`  in  32  fetch address; bits [2:0] ignored
- `if_stall`  out  1  fetcher lost arbitration; hold PC and request
- `if_rdata`  out  64  read data for fetcher
- `if_rvalid`  out  1  `if_rdata` valid
- `ls_req`  in  1  LSU requests an access
- `ls_we`  in  1  1 = write, 0 = read
- `ls_addr`  in  32  byte address; bits [2:0] ignored
- `ls_wdata`  in  64  write data
- `ls_wmask`  in  8  byte enables for writes
- `ls_stall`  out  1  LSU lost arbitration
- `ls_rdata`  out  64  read data for LSU
- `ls_rvalid`  out  1  `ls_rdata` valid (reads only)
- `mem_en`  out  1  port access this cycle
- `mem_we`  out  1  write strobe
- `mem_addr`  out  32  `{winner_addr[31:3],3'b000}`
- `mem_wdata`  out  64  write data
- `mem_wmask`  out  8  byte enables; 0 on reads
- `mem_rdata`  in  64  data for the access issued the previous cycle

## Operation
- Grant is combinational each cycle.
  - Only one requester asserted: that requester wins.
  - Both asserted: LSU wins, except when the guard is active (see Configuration).
- Loser's stall is high in the same cycle. Winner's stall is low. Non-requesting side's stall is low.
- Port drive:
  - `mem_en` = any grant.
  - `mem_we` = LSU grant & `ls_we`.
  - `mem_wdata` and `mem_wmask` come from the LSU on LSU writes; otherwise 0.
- Response owner register `owner` has states NONE, IF, LS_RD. It is loaded every cycle from the grant:
  - LSU write → NONE.
  - No request → NONE.
- The cycle after a grant:
  - `owner`=IF → `if_rvalid`=1, `if_rdata`=`mem_rdata`.
  - `owner`=LS_RD → `ls_rvalid`=1, `ls_rdata`=`mem_rdata`.
  - Non-owner rdata outputs are 0.
- The arbiter has no queue. Each requester must hold its request while stalled, and the arbiter re-evaluates every cycle.

## Timing
- Grant/stall latency: 0 cycles, combinational from `*_req`.
- Read latency: data and rvalid 1 cycle after the grant cycle. Back-to-back grants give one rvalid per cycle, and ownership may alternate cycle by cycle.
- Reset (synchronous):
  - `owner`=NONE and wait counter = 0.
  - While `reset`=1: `mem_en`, `mem_we`, both stalls and both rvalids are 0; all data outputs are 0.
- Reset asserted the cycle after a grant: the pending rvalid is suppressed, and the first cycle after reset has no rvalid.
- LSU write followed by a read to the same line: the read returns the written data (memory macro is write-first; the arbiter adds nothing).

## Configuration
- Macro `IMEM_ARB_STARVE_GUARD_EN`.
- Defined:
  - A saturating wait counter (4 bits) increments each cycle `if_req` & `ls_req` with LSU granted.
  - It clears on any IF grant, on a cycle with `if_req`=0, or on reset.
  - When counter == `MAX_WAIT` and both request, IF wins and LSU stalls; the counter then clears.
- Not defined: strict LSU priority, no counter logic; the fetcher may starve indefinitely.

## Test plan
- Reset: hold `reset` 2 cycles with both requests high → every output 0. Release → grant resumes the next cycle with no spurious rvalid.
- IF only: `if_req`=1, `if_addr`=0x104 → `mem_addr`=0x100, `if_stall`=0. Next cycle `mem_rdata`=0xAAAA_BBBB_CCCC_DDDD → `if_rvalid`=1 with that data, `ls_rvalid`=0.
- Contention: both request, LSU read at 0x200 → `if_stall`=1, `ls_stall`=0, `mem_addr`=0x200. Next cycle `ls_rvalid`=1.
- LSU write: `ls_we`=1, `ls_wmask`=0x0F, `ls_wdata`=0x1122334455667788 → `mem_we`=1 with matching mask and data. No rvalid the next cycle.
- Guard (macro defined, `MAX_WAIT`=4): both request continuously → LSU wins cycles 0–3, IF wins cycle 4 (`ls_stall`=1), LSU wins cycles 5–8, and so on. Macro undefined: LSU wins every cycle.
- Reset mid-read: IF granted in cycle N, `reset`=1 in N+1 → `if_rvalid`=0 in N+1 and N+2.
